// File: rtl/mem_channel_arbiter_if.sv
// mem_channel_arbiter_if: two-channel requester bus plus single-port memory bus
interface mem_channel_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [1:0] ch_oe;
  logic [1:0] ch_we;
  logic [2*ADDR_W-1:0] ch_addr;
  logic [2*DATA_W-1:0] ch_wdata;
  logic [2*SIZE_W-1:0] ch_size;
  logic [2*DATA_W-1:0] ch_rdata;
  logic [1:0] ch_rdy;
  logic mem_oe;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;
  logic busy;
  logic err_both;
  modport master (
    output ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_rdata,
    input ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_mask, busy, err_both
  );
  modport slave (
    input ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_rdata,
    output ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_mask, busy, err_both
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: round-robin arbiter of two Bambu memory channels onto one fixed-latency memory
module mem_channel_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4,
  parameter int BASE = 0,
  parameter int DEPTH = 32,
  parameter int READ_LAT = 2,
  parameter int WRITE_LAT = 1
) (
  input logic clock,
  input logic reset,
  mem_channel_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH);
  state_t state, state_nx;
  logic [1:0] req;
  logic gnt, g, last_grant, we_q, err_q, in_range, lat_hit;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [ADDR_W:0] off;
  logic [DATA_W-1:0] wdata_q, data_q, mask;
  logic [SIZE_W-1:0] size_q;
  logic [7:0] cnt, lat;
  assign req = (bus.ch_oe ^ bus.ch_we) & {2{~err_q}};
  assign gnt = &req ? ~last_grant : req[1];
  assign sel_addr = gnt ? bus.ch_addr[ADDR_W +: ADDR_W] : bus.ch_addr[0 +: ADDR_W];
  // Subtracting at ADDR_W+1 bits makes addresses below BASE wrap high, so one compare covers both bounds
  assign off = {1'b0, sel_addr} - LO;
  assign in_range = off < SPAN;
  assign lat = we_q ? 8'(WRITE_LAT) : 8'(READ_LAT);
  assign lat_hit = state == ISSUE ? lat == 8'd1 : cnt == lat - 8'd1;
  assign mask = int'(size_q) >= DATA_W ? {DATA_W{1'b1}} : ~({DATA_W{1'b1}} << size_q);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      g <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == ISSUE ? 8'd1 : state == WAIT ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && |(bus.ch_oe & bus.ch_we)) err_q <= 1'b1;
      if (state == IDLE && |req) begin
        g <= gnt;
        last_grant <= gnt;
        we_q <= gnt ? bus.ch_we[1] : bus.ch_we[0];
        addr_q <= off[ADDR_W-1:0];
        wdata_q <= gnt ? bus.ch_wdata[DATA_W +: DATA_W] : bus.ch_wdata[0 +: DATA_W];
        size_q <= gnt ? bus.ch_size[SIZE_W +: SIZE_W] : bus.ch_size[0 +: SIZE_W];
        data_q <= '0;
      end
      if ((state == ISSUE || state == WAIT) && lat_hit && !we_q) data_q <= bus.mem_rdata;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (|req ? (in_range ? ISSUE : DONE) : IDLE)
             : state == DONE ? IDLE
             : lat_hit ? DONE : WAIT;
    bus.mem_oe = state == ISSUE && !we_q;
    bus.mem_we = state == ISSUE && we_q;
    bus.mem_addr = state == ISSUE ? addr_q : '0;
    bus.mem_wdata = state == ISSUE && we_q ? wdata_q : '0;
    bus.mem_mask = state == ISSUE && we_q ? mask : '0;
    bus.ch_rdy = state == DONE ? (g ? 2'b10 : 2'b01) : 2'b00;
    bus.ch_rdata = state == DONE ? (g ? {data_q, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, data_q}) : '0;
    bus.busy = state != IDLE;
    bus.err_both = err_q;
  end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb_mem_channel_arbiter: transaction-level model with scoreboard queue checked by a monitor
module tb_mem_channel_arbiter;
  localparam int BASE = 0, DEPTH = 32, RL = 2, WL = 1;
  typedef struct {int ch; logic [7:0] d; int due;} exp_t;
  logic clock, reset;
  int cyc = 0, vectors = 0, miscompares = 0, last = 1;
  exp_t sb[$];
  logic [7:0] ext_mem [32];
  logic [7:0] ref_mem [32];
  logic [7:0] rd_d;
  logic p_on [2], p_we [2];
  logic [6:0] p_addr [2];
  logic [7:0] p_wd [2];
  logic [3:0] p_sz [2];
  mem_channel_arbiter_if bus ();
  mem_channel_arbiter dut (.clock(clock), .reset(reset), .bus(bus.slave));
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc++;
  always @(posedge clock) begin
    rd_d <= ext_mem[bus.mem_addr[4:0]];
    if (bus.mem_we)
      ext_mem[bus.mem_addr[4:0]] = (ext_mem[bus.mem_addr[4:0]] & ~bus.mem_mask) | (bus.mem_wdata & bus.mem_mask);
  end
  assign bus.mem_rdata = rd_d;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (bus.ch_rdy != 2'b00) begin
      if (sb.size() == 0) chk("spurious_rdy", bus.ch_rdy, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdy_channel", bus.ch_rdy, 64'(2'b01 << e.ch));
        chk("rdata", bus.ch_rdata, e.ch == 1 ? {e.d, 8'h00} : {8'h00, e.d});
        chk("rdy_cycle", cyc, e.due);
      end
    end else if (bus.ch_rdata != 16'h0) chk("rdata_idle", bus.ch_rdata, 0);
  end
  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      bus.ch_oe[c] = p_on[c] & !p_we[c];
      bus.ch_we[c] = p_on[c] & p_we[c];
      bus.ch_addr[c*7 +: 7] = p_addr[c];
      bus.ch_wdata[c*8 +: 8] = p_wd[c];
      bus.ch_size[c*4 +: 4] = p_sz[c];
    end
  endtask
  task automatic set_req(int c, logic we, logic [6:0] a, logic [7:0] wd, logic [3:0] sz);
    p_on[c] = 1; p_we[c] = we; p_addr[c] = a; p_wd[c] = wd; p_sz[c] = sz;
  endtask
  task automatic clear_all();
    p_on[0] = 0; p_on[1] = 0;
    drive();
  endtask
  task automatic do_reset();
    reset = 1;
    clear_all();
    tick(2);
    reset = 0;
    last = 1;
  endtask
  task automatic outs_zero(string nm);
    chk(nm, {bus.ch_rdy, bus.ch_rdata, bus.mem_oe, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.mem_mask, bus.busy, bus.err_both}, 0);
  endtask
  // One arbitration round from an idle arbiter: predict the winner, the data and the completion cycle
  task automatic round();
    int g, lt;
    logic inr;
    logic [7:0] d, m;
    drive();
    if (!p_on[0] && !p_on[1]) begin
      tick(1);
      return;
    end
    g = (p_on[0] && p_on[1]) ? 1 - last : (p_on[1] ? 1 : 0);
    last = g;
    inr = int'(p_addr[g]) >= BASE && int'(p_addr[g]) < BASE + DEPTH;
    m = p_sz[g] >= 8 ? 8'hFF : 8'((1 << p_sz[g]) - 1);
    d = 0;
    if (inr && !p_we[g]) d = ref_mem[p_addr[g] - BASE];
    if (inr && p_we[g]) ref_mem[p_addr[g] - BASE] = (ref_mem[p_addr[g] - BASE] & ~m) | (p_wd[g] & m);
    lt = inr ? 1 + (p_we[g] ? WL : RL) : 1;
    sb.push_back('{g, d, cyc + lt});
    tick(1);
    chk("busy", bus.busy, 1);
    chk("strobes", {bus.mem_oe, bus.mem_we}, {inr & !p_we[g], inr & p_we[g]});
    if (inr) chk("mem_addr", bus.mem_addr, p_addr[g] - BASE);
    if (inr && p_we[g]) chk("mem_mask_wdata", {bus.mem_mask, bus.mem_wdata}, {m, p_wd[g]});
    tick(lt);
    p_on[g] = 0;
    drive();
  endtask
  initial begin
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      ext_mem[i] = 8'($urandom);
      ref_mem[i] = ext_mem[i];
    end
    ext_mem[5] = 8'hA5;
    ref_mem[5] = 8'hA5;
    do_reset();
    outs_zero("reset_outputs");
    set_req(0, 0, 7'd5, 8'h00, 4'd8);
    round();
    set_req(1, 1, 7'd3, 8'hFF, 4'd4);
    round();
    set_req(0, 0, 7'd3, 8'h00, 4'd8);
    round();
    for (int i = 0; i < 4; i++) begin
      if (!p_on[0]) set_req(0, 0, 7'(i), 8'h00, 4'd8);
      if (!p_on[1]) set_req(1, 1, 7'(i + 8), 8'(i * 17), 4'(i + 5));
      round();
    end
    clear_all();
    set_req(0, 0, 7'd40, 8'h00, 4'd8);
    round();
    set_req(1, 1, 7'd2, 8'h3C, 4'd0);
    round();
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 2; c++)
        if (!p_on[c] && $urandom_range(0, 1) == 1)
          set_req(c, 1'($urandom), $urandom_range(0, 3) == 0 ? 7'($urandom_range(32, 127)) : 7'($urandom_range(0, 11)),
                  8'($urandom), 4'($urandom));
      round();
    end
    clear_all();
    tick(2);
    bus.ch_oe[0] = 1;
    bus.ch_we[0] = 1;
    tick(1);
    chk("err_set", bus.err_both, 1);
    clear_all();
    set_req(1, 0, 7'd4, 8'h00, 4'd8);
    drive();
    tick(5);
    chk("err_blocks_grant", {bus.busy, bus.err_both}, 2'b01);
    do_reset();
    chk("err_cleared", bus.err_both, 0);
    set_req(0, 0, 7'd6, 8'h00, 4'd8);
    drive();
    tick(2);
    reset = 1;
    tick(1);
    outs_zero("reset_in_wait");
    reset = 0;
    last = 1;
    clear_all();
    tick(1);
    set_req(1, 0, 7'd6, 8'h00, 4'd8);
    round();
    tick(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
